// File: rtl/regfl_seq_pkg.sv
// rtl/regfl_seq_pkg.sv - shared constants and state encoding for the regfl_seq micro-sequencer
//
// Holds the default data/address widths, the instruction opcodes and the
// sequencer state encoding. The regfl_seq and alu_add_sub files import it.

package regfl_seq_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int AW_DEF    = 2;

    localparam logic [2:0] OP_LDI  = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SWAP = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR1  = 3'd3,
        S_WR2  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/regfl_seq_alu_add_sub.sv
// rtl/regfl_seq_alu_add_sub.sv - WIDTH-bit adder/subtractor with carry/borrow out
//
// Computes lhs + rhs, or lhs - rhs when sub is high. carry_out is bit WIDTH
// of the full result: a carry for add, a borrow (lhs < rhs) for subtract.
// Config macro: REGFL_SEQ_SUB_EN adds the sub port and the subtract path;
// without it the block is a plain adder.
//
// Ports:
//   sub        in   1      select subtract (REGFL_SEQ_SUB_EN only)
//   lhs        in   WIDTH  left operand (destination register value)
//   rhs        in   WIDTH  right operand (source register value)
//   result     out  WIDTH  result modulo 2**WIDTH
//   carry_out  out  1      carry (add) or borrow (sub)

module alu_add_sub #(
    parameter int WIDTH = regfl_seq_pkg::WIDTH_DEF
) (
`ifdef REGFL_SEQ_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    logic [WIDTH:0] full;

    always_comb begin
`ifdef REGFL_SEQ_SUB_EN
        // Zero-extended subtraction wraps into bit WIDTH exactly when lhs < rhs.
        if (sub) begin
            full = {1'b0, lhs} - {1'b0, rhs};
        end else begin
            full = {1'b0, lhs} + {1'b0, rhs};
        end
`else
        full = {1'b0, lhs} + {1'b0, rhs};
`endif
    end

    assign result    = full[WIDTH-1:0];
    assign carry_out = full[WIDTH];

endmodule

// File: rtl/regfl_seq.sv
// rtl/regfl_seq.sv - micro-sequencer driving a register file's write and read ports
//
// Accepts one LDI/MOV/ADD/SWAP (and SUB) instruction per valid/ready handshake.
// Each instruction runs as a short read/read/write sequence against an
// external register file with a combinational read port. The carry/borrow
// of the last ADD/SUB is kept in carry.
// Config macro: REGFL_SEQ_SUB_EN makes opcode 100 a SUB (dst - src); without
// it, opcode 100 is rejected like any other illegal opcode.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr_op/dst/src/imm     opcode, destination, source, LDI immediate
//   rf_wr_e/addr/data        register file write port
//   rf_rd_addr/rf_rd_data    register file read port (same-cycle data)
//   done                     pulse in the final write cycle
//   err                      pulse when an illegal opcode is dropped
//   carry                    carry/borrow of the last ADD/SUB

module regfl_seq
    import regfl_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_dst,
    input  logic [AW-1:0]    instr_src,
    input  logic [WIDTH-1:0] instr_imm,
    output logic             rf_wr_e,
    output logic [AW-1:0]    rf_wr_addr,
    output logic [WIDTH-1:0] rf_wr_data,
    output logic [AW-1:0]    rf_rd_addr,
    input  logic [WIDTH-1:0] rf_rd_data,
    output logic             done,
    output logic             err,
    output logic             carry
);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic [AW-1:0]    dst_q;
    logic [AW-1:0]    src_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             accept;
    logic             is_arith;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    assign accept = instr_valid && (state == S_IDLE);

    // B holds the destination value, A the source, so SUB yields dst - src.
    alu_add_sub #(.WIDTH(WIDTH)) u_alu (
`ifdef REGFL_SEQ_SUB_EN
        .sub       (op_q == OP_SUB),
`endif
        .lhs       (b_q),
        .rhs       (a_q),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    always_comb begin
        is_arith = (op_q == OP_ADD);
`ifdef REGFL_SEQ_SUB_EN
        if (op_q == OP_SUB) begin
            is_arith = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            dst_q <= '0;
            src_q <= '0;
            imm_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= instr_op;
                dst_q <= instr_dst;
                src_q <= instr_src;
                imm_q <= instr_imm;
            end
            if (state == S_RD_A) begin
                a_q <= rf_rd_data;
            end
            if (state == S_RD_B) begin
                b_q <= rf_rd_data;
            end
            if ((state == S_WR1) && is_arith) begin
                carry <= alu_carry;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        rf_wr_e     = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        rf_rd_addr  = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    case (instr_op)
                        OP_LDI:  state_nxt = S_WR1;
                        OP_MOV,
                        OP_ADD,
                        OP_SWAP: state_nxt = S_RD_A;
`ifdef REGFL_SEQ_SUB_EN
                        OP_SUB:  state_nxt = S_RD_A;
`endif
                        default: state_nxt = S_ERR;
                    endcase
                end
            end
            S_RD_A: begin
                rf_rd_addr = src_q;
                state_nxt  = (op_q == OP_MOV) ? S_WR1 : S_RD_B;
            end
            S_RD_B: begin
                rf_rd_addr = dst_q;
                state_nxt  = S_WR1;
            end
            S_WR1: begin
                rf_wr_e    = 1'b1;
                rf_wr_addr = dst_q;
                case (op_q)
                    OP_LDI:          rf_wr_data = imm_q;
                    OP_MOV, OP_SWAP: rf_wr_data = a_q;
                    default:         rf_wr_data = alu_result;
                endcase
                if (op_q == OP_SWAP) begin
                    state_nxt = S_WR2;
                end else begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WR2: begin
                rf_wr_e    = 1'b1;
                rf_wr_addr = src_q;
                rf_wr_data = b_q;
                done       = 1'b1;
                state_nxt  = S_IDLE;
            end
            S_ERR: begin
                err       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
